// File: rtl/kvo_stream_checker.sv
// kvo_stream_checker
// Checks NCH independent key streams against a self-generated expected
// sequence. Each channel keeps its own expected counter. The counter starts
// at 0 and steps up or down by one on every qualified strobe. A slot whose
// expected value is 0 is never checked, which lets each stream resynchronise
// on its first word and on every wrap through 0.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        pulse: enter or restart RUN and wipe all results
//   clear        pulse: return to IDLE and wipe all results (wins over start)
//   vld[NCH]     per-channel strobe qualifying kvo
//   kvo          packed observed keys, channel i at [i*KW +: KW]
//   verdict      per-channel mismatch pulse, one cycle after the strobe
//   err_sticky   per-channel sticky mismatch flag
//   err_cnt      saturating total mismatch count
//   first_ch/first_exp/first_got/first_vld  capture of the first mismatch
//   busy, halted state indication (RUN, HALT)
module kvo_stream_checker #(
  parameter int KW          = 4,
  parameter int NCH         = 2,
  parameter int CW          = 8,
  parameter bit DOWN        = 1'b0,
  parameter bit HALT_ON_ERR = 1'b0,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [NCH-1:0]    vld,
  input  logic [NCH*KW-1:0] kvo,
  output logic [NCH-1:0]    verdict,
  output logic [NCH-1:0]    err_sticky,
  output logic [CW-1:0]     err_cnt,
  output logic [CHW-1:0]    first_ch,
  output logic [KW-1:0]     first_exp,
  output logic [KW-1:0]     first_got,
  output logic              first_vld,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e          state_q, state_d;
  logic [KW-1:0]   exp_q [NCH];
  logic [KW-1:0]   exp_d [NCH];
  logic [NCH-1:0]  verdict_q, verdict_d;
  logic [NCH-1:0]  err_sticky_q, err_sticky_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic [CHW-1:0]  first_ch_q, first_ch_d;
  logic [KW-1:0]   first_exp_q, first_exp_d;
  logic [KW-1:0]   first_got_q, first_got_d;
  logic            first_vld_q, first_vld_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [NCH-1:0]  mismatch_s;
  logic            check_en_s;
  logic            found_s;

  // Next expected key: modulo-2^KW step in the configured direction.
  function automatic logic [KW-1:0] step_exp(input logic [KW-1:0] e);
    if (DOWN) begin
      return e - KW'(1'b1);
    end else begin
      return e + KW'(1'b1);
    end
  endfunction

  // Per-channel compare; only live in an undisturbed RUN cycle.
  always_comb begin
    check_en_s = (state_q == ST_RUN) && !start && !clear;
    mismatch_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (check_en_s && vld[i] && (exp_q[i] != '0) &&
          (kvo[i*KW +: KW] != exp_q[i])) begin
        mismatch_s[i] = 1'b1;
      end else begin
        mismatch_s[i] = 1'b0;
      end
    end
  end

  // Next-state and result update logic.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    verdict_d    = '0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    first_ch_d   = first_ch_q;
    first_exp_d  = first_exp_q;
    first_got_d  = first_got_q;
    first_vld_d  = first_vld_q;
    found_s      = 1'b0;

    if (clear || start) begin
      // clear has priority: both wipe results, only start enters RUN
      state_d      = clear ? ST_IDLE : ST_RUN;
      for (int i = 0; i < NCH; i++) begin
        exp_d[i] = '0;
      end
      err_sticky_d = '0;
      err_cnt_d    = '0;
      first_ch_d   = '0;
      first_exp_d  = '0;
      first_got_d  = '0;
      first_vld_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < NCH; i++) begin
        if (vld[i]) begin
          exp_d[i] = step_exp(exp_q[i]);
        end else begin
          exp_d[i] = exp_q[i];
        end
      end
      verdict_d    = mismatch_s;
      err_sticky_d = err_sticky_q | mismatch_s;
      // One saturating increment per mismatching channel.
      for (int i = 0; i < NCH; i++) begin
        if (mismatch_s[i] && (err_cnt_d != CNT_MAX)) begin
          err_cnt_d = err_cnt_d + CW'(1'b1);
        end else begin
          err_cnt_d = err_cnt_d;
        end
      end
      // Lowest-index channel wins the capture; never overwritten afterwards.
      if (!first_vld_q) begin
        for (int i = 0; i < NCH; i++) begin
          if (mismatch_s[i] && !found_s) begin
            found_s     = 1'b1;
            first_ch_d  = CHW'(i);
            first_exp_d = exp_q[i];
            first_got_d = kvo[i*KW +: KW];
            first_vld_d = 1'b1;
          end else begin
            found_s = found_s;
          end
        end
      end else begin
        first_vld_d = first_vld_q;
      end
      if (HALT_ON_ERR && (|mismatch_s)) begin
        state_d = ST_HALT;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      // IDLE and HALT ignore strobes; expected counters stay frozen.
      state_d = state_q;
    end

    busy_d   = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  // State, expected counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NCH; i++) begin
        exp_q[i] <= '0;
      end
      verdict_q    <= '0;
      err_sticky_q <= '0;
      err_cnt_q    <= '0;
      first_ch_q   <= '0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
      first_vld_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      verdict_q    <= verdict_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      first_ch_q   <= first_ch_d;
      first_exp_q  <= first_exp_d;
      first_got_q  <= first_got_d;
      first_vld_q  <= first_vld_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
    end
  end

  assign verdict    = verdict_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign first_ch   = first_ch_q;
  assign first_exp  = first_exp_q;
  assign first_got  = first_got_q;
  assign first_vld  = first_vld_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: doc/kvo_stream_checker.md
KVO_STREAM_CHECKER -- requirements
Module: kvo_stream_checker

Interface
REQ-001 Parameter KW, default 4, is the key width in bits.
REQ-002 Parameter NCH, default 2, is the number of independent checked channels (NCH >= 1).
REQ-003 Parameter CW, default 8, is the error-counter width.
REQ-004 Parameter DOWN, default 0: 0 means expected sequence ascends, 1 means it descends.
REQ-005 Parameter HALT_ON_ERR, default 0: 1 means stop checking after the first mismatch.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  single-cycle pulse that begins or restarts a check run.
REQ-009 clear  in  1  single-cycle pulse that returns the block to idle and wipes all results.
REQ-010 vld  in  NCH  per-channel strobe; bit i qualifies kvo of channel i.
REQ-011 kvo  in  NCH*KW  packed observed keys; channel i occupies bits [i*KW +: KW].
REQ-012 verdict  out  NCH  per-channel mismatch pulse.
REQ-013 err_sticky  out  NCH  per-channel sticky mismatch flag.
REQ-014 err_cnt  out  CW  total mismatches since last start/clear.
REQ-015 first_ch  out  max(1,clog2(NCH))  channel of first mismatch.
REQ-016 first_exp  out  KW  expected value at first mismatch.
REQ-017 first_got  out  KW  observed value at first mismatch.
REQ-018 first_vld  out  1  first_* fields hold a captured mismatch.
REQ-019 busy  out  1  high in RUN.
REQ-020 halted  out  1  high in HALT.

Function
REQ-021 FSM states SHALL be IDLE, RUN, HALT.
REQ-022 Transitions: IDLE-start->RUN; RUN-start->RUN (restart); RUN-mismatch with HALT_ON_ERR=1->HALT; HALT-start->RUN; any state-clear->IDLE; clear SHALL take priority over start.
REQ-023 Entering or restarting RUN SHALL set every per-channel expected counter exp[i] to 0 and zero err_sticky, err_cnt, first_* and first_vld in the same edge.
REQ-024 In RUN, for each i with vld[i]=1: mismatch[i] = (exp[i] != 0) && (kvo[i] != exp[i]); then exp[i] steps +1 (DOWN=0) or -1 (DOWN=1) modulo 2^KW.
REQ-025 exp[i]=0 SHALL be a don't-check slot: the first strobe after start and every wrap through 0 are never flagged.
REQ-026 vld in IDLE or HALT SHALL be ignored: no counter step, no flags.
REQ-027 verdict[i] SHALL be high exactly one cycle after a strobe with mismatch[i]=1 and low otherwise (one-cycle latency, registered).
REQ-028 err_sticky[i] SHALL set on mismatch[i] and hold until start or clear.
REQ-029 err_cnt SHALL add popcount(mismatch) each cycle, saturating at 2^CW-1 without wrap.
REQ-030 first_* SHALL capture on the first mismatch after start; simultaneous mismatches resolve to the lowest channel index; later mismatches SHALL NOT overwrite.
REQ-031 On entry to HALT all exp[i] SHALL freeze; the mismatch cycle that caused HALT SHALL still be counted and flagged.
REQ-032 All outputs SHALL be registered; busy/halted reflect current state.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, all exp[i]=0, and every output to 0.
REQ-034 rst_n deassertion SHALL take effect on the next clk edge; start during that edge is honoured.

Verification
REQ-035 KW=4,NCH=1,DOWN=0: start, then kvo 0,1,2,3 on consecutive vld -> verdict never high, err_cnt=0.
REQ-036 NCH=2: start; ch0 sends 0,1,5; ch1 sends 0,1,2 -> verdict[0] high one cycle after third strobe, err_cnt=1, first_ch=0, first_exp=2, first_got=5.
REQ-037 Simultaneous mismatch on ch0 and ch1 in same cycle -> err_cnt=2, first_ch=0; 16 strobes ascending from 0 on ch0 -> wrap to exp 0 not flagged.
REQ-038 HALT_ON_ERR=1, mismatch then further vld -> halted=1, err_cnt=1 frozen; start -> busy=1, err_cnt=0.
REQ-039 CW=2, five mismatches -> err_cnt saturates at 3; clear and start same cycle -> IDLE, all outputs 0.
REQ-040 rst_n asserted mid-RUN between clock edges -> all outputs 0 immediately, state IDLE.
